spi_master_arbiter: RTL and testbench

//  Shares one Mode-0 SPI master between NREQ requesters (one slave per requester).

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_rr_pick.sv | 31 +++
 rtl/spi_master_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared state encoding, default sizes and index helper for the SPI master arbiter.
package spi_arb_pkg;

  localparam int SPI_ARB_WIDTH_DEF = 8;
  localparam int SPI_ARB_NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Requester index k positions after base, wrapping at n.
  function automatic int rr_offset(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_grant+1 wins.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = SPI_ARB_NREQ_DEF
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any_vld
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] idx_w;

  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    idx_w   = '0;
    // k=NREQ lands back on last_grant, so it is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      idx_w = IDX_W'(rr_offset(32'(last_grant), k, NREQ));
      if (!any_vld && req_valid[idx_w]) begin
        grant   = idx_w;
        any_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin share of one SPI master among NREQ requesters: accept, start, wait for done, respond.
// Optional WAIT timeout with error response when SPI_ARB_TIMEOUT_EN is defined.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = SPI_ARB_NREQ_DEF,
  parameter int WIDTH       = SPI_ARB_WIDTH_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    m_start,
  output logic [WIDTH-1:0]        m_data_in,
  input  logic                    m_done,
  input  logic [WIDTH-1:0]        m_data_out,
  output logic [NREQ-1:0]         cs_sel
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_master_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("spi_master_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             m_start_q, m_start_d;
  logic [WIDTH-1:0] m_data_in_q, m_data_in_d;
  logic [NREQ-1:0]  cs_sel_q, cs_sel_d;

  logic [IDX_W-1:0] pick_grant;
  logic             pick_any;
  logic [NREQ-1:0]  pick_oh;
  logic [NREQ-1:0]  grant_oh;
  logic             tmo_fire;
  logic [WIDTH-1:0] req_word [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[i*WIDTH +: WIDTH];
  end

  spi_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant_q),
    .grant     (pick_grant),
    .any_vld   (pick_any)
  );

  assign pick_oh  = NREQ'(1) << pick_grant;
  assign grant_oh = NREQ'(1) << grant_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             tmo_hit;

  assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
  assign tmo_fire = (state_q == WAIT) && tmo_hit;

  // Counting starts once the master has seen m_start, not in the start cycle itself.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == START) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (m_done || tmo_hit) begin
        rsp_err_d = !m_done;
      end else if (!m_start_q) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign tmo_fire = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    m_start_d    = 1'b0;
    m_data_in_d  = m_data_in_q;
    cs_sel_d     = cs_sel_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_grant;
          m_data_in_d = req_word[pick_grant];
          req_ready_d = pick_oh;
          cs_sel_d    = pick_oh;
          state_d     = START;
        end
      end
      START: begin
        m_start_d = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // Response is registered here so rsp_valid shows in the cycle after m_done.
        if (m_done || tmo_fire) begin
          rsp_valid_d = grant_oh;
          rsp_data_d  = m_done ? m_data_out : '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        cs_sel_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      m_start_q    <= 1'b0;
      m_data_in_q  <= '0;
      cs_sel_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      m_start_q    <= m_start_d;
      m_data_in_q  <= m_data_in_d;
      cs_sel_q     <= cs_sel_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;
  assign cs_sel    = cs_sel_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter with a behavioural SPI master/slave model and response scoreboard.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ        = 4;
  localparam int WIDTH       = 8;
  localparam int TIMEOUT_CYC = 32;
  localparam int XFER        = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  m_start;
  logic [WIDTH-1:0]      m_data_in;
  logic                  m_done;
  logic [WIDTH-1:0]      m_data_out;
  logic [NREQ-1:0]       cs_sel;

  spi_master_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_start(m_start), .m_data_in(m_data_in),
    .m_done(m_done), .m_data_out(m_data_out), .cs_sel(cs_sel)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] rx; logic err; int lat; } exp_t;
  typedef struct { int idx; logic [7:0] tx; logic [7:0] slv; } vec_t;

  exp_t            exp_q[$];
  int              grants[$];
  vec_t            vecs[5];
  logic [7:0]      slave_tx[NREQ];
  logic [7:0]      slave_rx[NREQ];
  logic [7:0]      tx_of[NREQ];
  logic [7:0]      cur_tx = '0;
  logic [NREQ-1:0] prev_rsp = '0;
  logic            hold = 1'b0;
  int              n_cmp = 0, n_bad = 0;
  int              cyc = 0, start_cyc = 0, rsp_cnt = 0, cur_g = -1, spur_cnt = 0;

  // Master + slaves: on m_start, slave[cs] captures the TX word and returns its byte XFER cycles later.
  initial begin
    int mi;
    int spur_seen;
    spur_seen  = 0;
    m_done     = 1'b0;
    m_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_cnt != spur_seen) begin
        spur_seen  = spur_cnt;
        m_done     = 1'b1;
        m_data_out = 8'hEE;
        @(posedge clk); #1;
        m_done = 1'b0;
      end else if (m_start && !hold) begin
        mi = 0;
        for (int i = 0; i < NREQ; i++) if (cs_sel[i]) mi = i;
        slave_rx[mi] = m_data_in;
        repeat (XFER) @(posedge clk);
        #1;
        m_done     = 1'b1;
        m_data_out = slave_tx[mi];
        @(posedge clk); #1;
        m_done     = 1'b0;
        m_data_out = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // One clock; observes grants and responses against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    if (req_ready != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          cur_g  = i;
          cur_tx = tx_of[i];
          grants.push_back(i);
        end
      end
      chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
      req_valid = req_valid & ~req_ready;
    end
    if (m_start) start_cyc = cyc;
    if (cs_sel != '0) begin
      chk("cs_sel", 32'(cs_sel), 32'd1 << cur_g);
      chk("m_data_in", 32'(m_data_in), 32'(cur_tx));
    end
    if (rsp_valid != '0) begin
      chk("rsp_pulse_width", 32'(prev_rsp), 32'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
        chk("rsp_data", 32'(rsp_data), 32'(e.rx));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", cyc - start_cyc, e.lat);
      end
      rsp_cnt++;
    end
    prev_rsp = rsp_valid;
  endtask

  task automatic issue(input int idx, input logic [7:0] tx, input logic [7:0] slv);
    exp_t e;
    tx_of[idx]    = tx;
    slave_tx[idx] = slv;
    req_data[idx*WIDTH +: WIDTH] = tx;
    req_valid[idx] = 1'b1;
    e = '{idx: idx, rx: slv, err: 1'b0, lat: XFER + 1};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    req_valid = '0;
    step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst       = 1'b0;
    req_valid = '0;
    cur_g     = -1;
    exp_q.delete();
    step();
  endtask

  initial begin
    int r0;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      slave_tx[i] = '0;
      slave_rx[i] = '0;
      tx_of[i]    = '0;
    end

    vecs[0] = '{idx: 0, tx: 8'hA5, slv: 8'h5A};
    vecs[1] = '{idx: 0, tx: 8'h3C, slv: 8'hC3};
    vecs[2] = '{idx: 3, tx: 8'h81, slv: 8'h18};
    vecs[3] = '{idx: 2, tx: 8'h0F, slv: 8'hF0};
    vecs[4] = '{idx: 1, tx: 8'hE7, slv: 8'h7E};

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_m_data_in", 32'(m_data_in), 32'd0);
    chk("rst_cs_sel", 32'(cs_sel), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_last_grant", 32'(dut.last_grant_q), 32'(NREQ - 1));
    rst = 1'b0;
    step();

    // Single-requester vectors, including consecutive grants to requester 0
    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].idx, vecs[v].tx, vecs[v].slv);
      step();
      chk("accept_latency", 32'(req_ready), 32'd1 << vecs[v].idx);
      chk("start_not_early", 32'(m_start), 32'd0);
      step();
      chk("start_latency", 32'(m_start), 32'd1);
      chk("ready_one_cycle", 32'(req_ready), 32'd0);
      drain("vec", 200);
      chk("slave_rx", 32'(slave_rx[vecs[v].idx]), 32'(vecs[v].tx));
    end

    // All four at once from reset: grants rotate 0,1,2,3
    reset_dut();
    grants.delete();
    issue(0, 8'h11, 8'hB0);
    issue(1, 8'h22, 8'hB1);
    issue(2, 8'h33, 8'hB2);
    issue(3, 8'h44, 8'hB3);
    drain("all4", 400);
    chk("all4_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("all4_grant_order", (grants.size() > i) ? grants[i] : -1, i);
      chk("all4_slave_rx", 32'(slave_rx[i]), 32'(8'h11 * (i + 1)));
    end

    // After last_grant=1, req1 and req2 together: 2 wins, then 1
    issue(1, 8'h55, 8'hAA);
    drain("lg1", 200);
    grants.delete();
    issue(2, 8'h66, 8'h99);
    issue(1, 8'h77, 8'h88);
    drain("rr12", 300);
    chk("rr12_count", grants.size(), 2);
    chk("rr12_first", (grants.size() > 0) ? grants[0] : -1, 2);
    chk("rr12_second", (grants.size() > 1) ? grants[1] : -1, 1);

    // Reset while waiting on the master
    hold = 1'b1;
    tx_of[1] = 8'h77;
    req_data[1*WIDTH +: WIDTH] = 8'h77;
    req_valid[1] = 1'b1;
    n = 0;
    while (!m_start && n < 10) begin
      step();
      n++;
    end
    chk("rstwait_start_seen", 32'(m_start), 32'd1);
    step();
    step();
    chk("rstwait_in_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    step();
    chk("rstwait_req_ready", 32'(req_ready), 32'd0);
    chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait_rsp_data", 32'(rsp_data), 32'd0);
    chk("rstwait_m_start", 32'(m_start), 32'd0);
    chk("rstwait_m_data_in", 32'(m_data_in), 32'd0);
    chk("rstwait_cs_sel", 32'(cs_sel), 32'd0);
    chk("rstwait_state", 32'(dut.state_q), 32'(IDLE));
    rst       = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    cur_g     = -1;
    step();
    issue(3, 8'hC3, 8'h3C);
    drain("post_rst", 200);
    chk("post_rst_slave_rx", 32'(slave_rx[3]), 32'hC3);

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never answers: error response TIMEOUT_CYC+1 cycles after m_start
    begin
      exp_t e;
      hold = 1'b1;
      tx_of[2] = 8'h99;
      req_data[2*WIDTH +: WIDTH] = 8'h99;
      req_valid[2] = 1'b1;
      e = '{idx: 2, rx: 8'h00, err: 1'b1, lat: TIMEOUT_CYC + 1};
      exp_q.push_back(e);
      drain("timeout", TIMEOUT_CYC + 20);
      hold = 1'b0;
    end
`endif

    // Spurious m_done in IDLE
    r0 = rsp_cnt;
    spur_cnt++;
    repeat (4) step();
    chk("spur_no_rsp", rsp_cnt, r0);
    chk("spur_state", 32'(dut.state_q), 32'(IDLE));
    chk("spur_cs_sel", 32'(cs_sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
